// File: rtl/dm_pkg.sv
// Shared types and helper functions for the data-memory access path.
package dm_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = 4;
    localparam int unsigned TYPE_W = 3;
    localparam int unsigned CNT_W  = 8;

    // Load/store size and signedness codes carried on DMType
    typedef enum logic [TYPE_W-1:0] {
        dm_word              = 3'b000,
        dm_halfword          = 3'b001,
        dm_halfword_unsigned = 3'b010,
        dm_byte              = 3'b011,
        dm_byte_unsigned     = 3'b100
    } dm_type_e;

    // Access sequencer states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } dm_state_e;

    // Access width after decoding; unknown codes collapse to word
    typedef enum logic [1:0] {
        SZ_WORD = 2'd0,
        SZ_HALF = 2'd1,
        SZ_BYTE = 2'd2
    } dm_size_e;

    // Store payload after lane steering
    typedef struct packed {
        logic [BE_W-1:0]   be;
        logic [DATA_W-1:0] data;
    } dm_lanes_t;

    function automatic dm_size_e access_size(input logic [TYPE_W-1:0] t);
        case (t)
            dm_halfword, dm_halfword_unsigned: access_size = SZ_HALF;
            dm_byte, dm_byte_unsigned:         access_size = SZ_BYTE;
            default:                           access_size = SZ_WORD;
        endcase
    endfunction

    function automatic logic is_signed_type(input logic [TYPE_W-1:0] t);
        is_signed_type = (t == dm_halfword) || (t == dm_byte);
    endfunction

    function automatic logic is_misaligned(input logic [TYPE_W-1:0] t, input logic [1:0] o);
        case (access_size(t))
            SZ_HALF: is_misaligned = o[0];
            SZ_BYTE: is_misaligned = 1'b0;
            default: is_misaligned = (o != 2'b00);
        endcase
    endfunction

    function automatic logic [BE_W-1:0] byte_enable(input logic [TYPE_W-1:0] t, input logic [1:0] o);
        case (access_size(t))
            SZ_HALF: byte_enable = BE_W'(4'b0011 << o);
            SZ_BYTE: byte_enable = BE_W'(4'b0001 << o);
            default: byte_enable = 4'b1111;
        endcase
    endfunction

    // Replicate the store data across every lane so the byte enables pick the target
    function automatic dm_lanes_t store_lanes(input logic [TYPE_W-1:0] t, input logic [1:0] o,
                                              input logic [DATA_W-1:0] wd);
        store_lanes.be = byte_enable(t, o);
        case (access_size(t))
            SZ_HALF: store_lanes.data = {2{wd[15:0]}};
            SZ_BYTE: store_lanes.data = {4{wd[7:0]}};
            default: store_lanes.data = wd;
        endcase
    endfunction

endpackage

// File: rtl/dm_load_extend.sv
// Load lane selection and sign/zero extension; purely combinational.
module dm_load_extend
    import dm_pkg::*;
(
    input  logic [DATA_W-1:0] rdata,
    input  logic [1:0]        offset,
    input  logic [TYPE_W-1:0] dm_type,
    output logic [DATA_W-1:0] ext_data_c
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    // Pick the byte and halfword lanes addressed by the offset
    always_comb begin
        byte_lane = rdata[7:0];
        case (offset)
            2'd1:    byte_lane = rdata[15:8];
            2'd2:    byte_lane = rdata[23:16];
            2'd3:    byte_lane = rdata[31:24];
            default: byte_lane = rdata[7:0];
        endcase
        half_lane = offset[1] ? rdata[31:16] : rdata[15:0];
    end

    // Extend the selected lane to a full word
    always_comb begin
        ext_data_c = rdata;
        case (access_size(dm_type))
            SZ_HALF: ext_data_c = is_signed_type(dm_type) ? {{16{half_lane[15]}}, half_lane}
                                                          : {16'b0, half_lane};
            SZ_BYTE: ext_data_c = is_signed_type(dm_type) ? {{24{byte_lane[7]}}, byte_lane}
                                                          : {24'b0, byte_lane};
            default: ext_data_c = rdata;
        endcase
    end

endmodule

// File: rtl/dm_access_unit.sv
// Sequences one load/store per instruction over a req/ack bus and stalls the core meanwhile.
module dm_access_unit
    import dm_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned ADDR_W         = 32
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [2:0]        DMType,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       readdata,
    output logic              stall,
    output logic              misalign,
    output logic              bus_err,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [3:0]        bus_be,
    output logic [31:0]       bus_wdata,
    input  logic [31:0]       bus_rdata,
    input  logic              bus_ack
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    dm_state_e         state, state_next;
    logic [CNT_W-1:0]  cnt, cnt_d;
    logic [TYPE_W-1:0] type_q, type_d;
    logic [1:0]        off_q, off_d;

    logic [31:0]       readdata_d;
    logic              misalign_d, bus_err_d, bus_req_d, bus_we_d;
    logic [ADDR_W-1:0] bus_addr_d;
    logic [3:0]        bus_be_d;
    logic [31:0]       bus_wdata_d;

    logic              misaligned_c;
    logic              timeout_c;
    logic [31:0]       load_data_c;
    dm_lanes_t         lanes_c;

    assign misaligned_c = is_misaligned(DMType, addr[1:0]);
    assign timeout_c    = (32'(cnt) + 32'd1) >= TIMEOUT_CYCLES;
    assign lanes_c      = store_lanes(DMType, addr[1:0], wdata);

    // Extract the load result from the latched size and offset
    dm_load_extend u_load_extend (
        .rdata      (bus_rdata),
        .offset     (off_q),
        .dm_type    (type_q),
        .ext_data_c (load_data_c)
    );

    // Stall while a memory instruction is pending; released in DONE and held low during reset
    assign stall = rstn & mem_req & (state != ST_DONE);

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; DONE always lasts one cycle so the instruction is never re-issued
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (mem_req) begin
                    state_next = misaligned_c ? ST_DONE : ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (bus_ack || timeout_c) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs and latched request fields
    always_comb begin
        cnt_d       = cnt;
        type_d      = type_q;
        off_d       = off_q;
        readdata_d  = readdata;
        misalign_d  = 1'b0;
        bus_err_d   = 1'b0;
        bus_req_d   = 1'b0;
        bus_we_d    = bus_we;
        bus_addr_d  = bus_addr;
        bus_be_d    = bus_be;
        bus_wdata_d = bus_wdata;
        case (state)
            ST_IDLE: begin
                if (mem_req) begin
                    if (misaligned_c) begin
                        misalign_d = 1'b1;
                        readdata_d = '0;
                    end else begin
                        bus_req_d   = 1'b1;
                        bus_we_d    = mem_we;
                        bus_addr_d  = {addr[ADDR_W-1:2], 2'b00};
                        bus_be_d    = lanes_c.be;
                        bus_wdata_d = lanes_c.data;
                        type_d      = DMType;
                        off_d       = addr[1:0];
                        cnt_d       = '0;
                    end
                end
            end
            ST_BUSY: begin
                if (bus_ack) begin
                    if (!bus_we) begin
                        readdata_d = load_data_c;
                    end
                    bus_we_d = 1'b0;
                    bus_be_d = '0;
                end else if (timeout_c) begin
                    bus_err_d  = 1'b1;
                    readdata_d = '0;
                    bus_we_d   = 1'b0;
                    bus_be_d   = '0;
                end else begin
                    bus_req_d = 1'b1;
                    cnt_d     = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
                end
            end
            default: begin
            end
        endcase
    end

    // Output and request-field registers; reset abandons any in-flight access
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt       <= '0;
            type_q    <= '0;
            off_q     <= '0;
            readdata  <= '0;
            misalign  <= 1'b0;
            bus_err   <= 1'b0;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_be    <= '0;
            bus_wdata <= '0;
        end else begin
            cnt       <= cnt_d;
            type_q    <= type_d;
            off_q     <= off_d;
            readdata  <= readdata_d;
            misalign  <= misalign_d;
            bus_err   <= bus_err_d;
            bus_req   <= bus_req_d;
            bus_we    <= bus_we_d;
            bus_addr  <= bus_addr_d;
            bus_be    <= bus_be_d;
            bus_wdata <= bus_wdata_d;
        end
    end

endmodule

// File: tb/tb_dm_access_unit.sv
// Scoreboard bench for dm_access_unit with a simple req/ack bus responder.
module tb_dm_access_unit;
    import dm_pkg::*;

    typedef struct {
        logic [31:0] rd;
        logic        mis;
        logic        berr;
        int          req_n;
        int          stall_n;
        logic [31:0] addr;
        logic [3:0]  be;
        logic        we;
        logic [31:0] wd;
    } exp_t;

    logic        clk;
    logic        rstn;
    logic        mem_req;
    logic        mem_we;
    logic [2:0]  dm_type;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] readdata;
    logic        stall;
    logic        misalign;
    logic        bus_err;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ack;

    int total = 0;
    int bad   = 0;

    exp_t sb_q[$];
    exp_t mon_e;

    int          ack_dly;
    logic [31:0] rsp_data;
    int          rsp_cnt;

    int          stall_n;
    int          req_n;
    logic        unstable;
    logic [31:0] cap_addr;
    logic [3:0]  cap_be;
    logic        cap_we;
    logic [31:0] cap_wd;

    dm_access_unit #(
        .TIMEOUT_CYCLES (4),
        .ADDR_W         (32)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .DMType    (dm_type),
        .addr      (addr),
        .wdata     (wdata),
        .readdata  (readdata),
        .stall     (stall),
        .misalign  (misalign),
        .bus_err   (bus_err),
        .bus_req   (bus_req),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_be    (bus_be),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata),
        .bus_ack   (bus_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    function automatic exp_t mk_exp(input logic [31:0] rd, input logic mis, input logic berr,
                                    input int rq, input int st, input logic [31:0] a,
                                    input logic [3:0] be, input logic we, input logic [31:0] wd);
        exp_t e;
        e.rd = rd; e.mis = mis; e.berr = berr; e.req_n = rq; e.stall_n = st;
        e.addr = a; e.be = be; e.we = we; e.wd = wd;
        return e;
    endfunction

    // Bus responder: acks after ack_dly BUSY cycles (negative = never)
    always @(negedge clk) begin
        if (bus_req) begin
            bus_ack   = (ack_dly >= 0) && (rsp_cnt == ack_dly);
            bus_rdata = bus_ack ? rsp_data : 32'h5A5A_5A5A;
            rsp_cnt   = rsp_cnt + 1;
        end else begin
            bus_ack   = 1'b0;
            bus_rdata = 32'h5A5A_5A5A;
            rsp_cnt   = 0;
        end
    end

    // Monitor: counts stall/request cycles and scores each access in its DONE cycle
    always @(negedge clk) begin
        if (rstn && mem_req) begin
            if (stall) begin
                stall_n = stall_n + 1;
                if (bus_req) begin
                    if (req_n == 0) begin
                        cap_addr = bus_addr; cap_be = bus_be; cap_we = bus_we; cap_wd = bus_wdata;
                    end else if (cap_addr !== bus_addr || cap_be !== bus_be ||
                                 cap_we !== bus_we || cap_wd !== bus_wdata) begin
                        unstable = 1'b1;
                    end
                    req_n = req_n + 1;
                end
            end else if (sb_q.size() == 0) begin
                check_eq("sb_empty", 32'd1, 32'd0);
            end else begin
                mon_e = sb_q.pop_front();
                check_eq("readdata", readdata, mon_e.rd);
                check_eq("misalign", 32'(misalign), 32'(mon_e.mis));
                check_eq("bus_err", 32'(bus_err), 32'(mon_e.berr));
                check_eq("done_req", 32'(bus_req), 32'd0);
                check_eq("req_cycles", 32'(req_n), 32'(mon_e.req_n));
                check_eq("stall_cycles", 32'(stall_n), 32'(mon_e.stall_n));
                if (mon_e.req_n > 0) begin
                    check_eq("bus_addr", cap_addr, mon_e.addr);
                    check_eq("bus_be", 32'(cap_be), 32'(mon_e.be));
                    check_eq("bus_we", 32'(cap_we), 32'(mon_e.we));
                    check_eq("bus_wdata", cap_wd, mon_e.wd);
                    check_eq("bus_stable", 32'(unstable), 32'd0);
                end
                stall_n = 0; req_n = 0; unstable = 1'b0;
            end
        end else begin
            stall_n = 0; req_n = 0; unstable = 1'b0;
        end
    end

    task automatic issue(input logic we, input logic [2:0] t, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] rd, input int dly, input exp_t e);
        bit done;
        sb_q.push_back(e);
        ack_dly  = dly;
        rsp_data = rd;
        @(posedge clk); #1;
        mem_req = 1'b1; mem_we = we; dm_type = t; addr = a; wdata = wd;
        done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!stall) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) begin
            check_eq("done_timeout", 32'd0, 32'd1);
            if (sb_q.size() > 0) void'(sb_q.pop_back());
        end
        @(posedge clk); #1;
        mem_req = 1'b0; mem_we = 1'b0; wdata = '0;
        @(negedge clk);
        check_eq("pulse_misalign", 32'(misalign), 32'd0);
        check_eq("pulse_bus_err", 32'(bus_err), 32'd0);
    endtask

    initial begin
        rstn = 1'b0; mem_req = 1'b0; mem_we = 1'b0; dm_type = '0; addr = '0; wdata = '0;
        ack_dly = -1; rsp_data = '0;
        stall_n = 0; req_n = 0; unstable = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_readdata", readdata, 32'h0);
        check_eq("rst_stall", 32'(stall), 32'd0);
        check_eq("rst_bus_req", 32'(bus_req), 32'd0);
        check_eq("rst_bus_we", 32'(bus_we), 32'd0);
        check_eq("rst_bus_be", 32'(bus_be), 32'd0);
        check_eq("rst_flags", {30'b0, misalign, bus_err}, 32'd0);
        rstn = 1'b1;

        issue(0, dm_word, 32'h1004, 0, 32'hDEAD_BEEF, 0,
              mk_exp(32'hDEAD_BEEF, 0, 0, 1, 2, 32'h1004, 4'b1111, 0, 32'h0));
        issue(0, dm_byte, 32'h1003, 0, 32'h80FF_0000, 0,
              mk_exp(32'hFFFF_FF80, 0, 0, 1, 2, 32'h1000, 4'b1000, 0, 32'h0));
        issue(0, dm_byte_unsigned, 32'h1003, 0, 32'h80FF_0000, 0,
              mk_exp(32'h0000_0080, 0, 0, 1, 2, 32'h1000, 4'b1000, 0, 32'h0));
        issue(0, dm_halfword_unsigned, 32'h1002, 0, 32'h80FF_0000, 0,
              mk_exp(32'h0000_80FF, 0, 0, 1, 2, 32'h1000, 4'b1100, 0, 32'h0));
        issue(0, dm_halfword, 32'h1002, 0, 32'h80FF_0000, 2,
              mk_exp(32'hFFFF_80FF, 0, 0, 3, 4, 32'h1000, 4'b1100, 0, 32'h0));
        issue(1, dm_byte, 32'h2001, 32'h1234_56AB, 0, 0,
              mk_exp(32'hFFFF_80FF, 0, 0, 1, 2, 32'h2000, 4'b0010, 1, 32'hABAB_ABAB));
        issue(1, dm_halfword, 32'h2002, 32'h1234_56AB, 0, 1,
              mk_exp(32'hFFFF_80FF, 0, 0, 2, 3, 32'h2000, 4'b1100, 1, 32'h56AB_56AB));
        issue(1, dm_word, 32'h3000, 32'hCAFE_F00D, 0, 0,
              mk_exp(32'hFFFF_80FF, 0, 0, 1, 2, 32'h3000, 4'b1111, 1, 32'hCAFE_F00D));
        issue(0, dm_word, 32'h1002, 0, 32'h1111_1111, 0,
              mk_exp(32'h0, 1, 0, 0, 1, 32'h0, 4'b0, 0, 32'h0));
        issue(0, dm_byte, 32'h1001, 0, 32'h0000_7F00, 0,
              mk_exp(32'h0000_007F, 0, 0, 1, 2, 32'h1000, 4'b0010, 0, 32'h0));
        issue(0, dm_halfword_unsigned, 32'h1001, 0, 32'h2222_2222, 0,
              mk_exp(32'h0, 1, 0, 0, 1, 32'h0, 4'b0, 0, 32'h0));
        issue(0, dm_byte, 32'h1001, 0, 32'h0000_7F00, 0,
              mk_exp(32'h0000_007F, 0, 0, 1, 2, 32'h1000, 4'b0010, 0, 32'h0));
        issue(0, dm_word, 32'h1008, 0, 32'h3333_3333, -1,
              mk_exp(32'h0, 0, 1, 4, 5, 32'h1008, 4'b1111, 0, 32'h0));
        issue(0, dm_word, 32'h100C, 0, 32'h1122_3344, 0,
              mk_exp(32'h1122_3344, 0, 0, 1, 2, 32'h100C, 4'b1111, 0, 32'h0));
        issue(0, 3'b111, 32'h1001, 0, 32'h4444_4444, 0,
              mk_exp(32'h0, 1, 0, 0, 1, 32'h0, 4'b0, 0, 32'h0));
        issue(0, 3'b110, 32'h1024, 0, 32'h89AB_CDEF, 0,
              mk_exp(32'h89AB_CDEF, 0, 0, 1, 2, 32'h1024, 4'b1111, 0, 32'h0));

        // Reset while an access is waiting on the bus
        ack_dly = -1;
        @(posedge clk); #1;
        mem_req = 1'b1; mem_we = 1'b0; dm_type = dm_word; addr = 32'h1010;
        @(posedge clk); #1;
        check_eq("pre_rst_bus_req", 32'(bus_req), 32'd1);
        check_eq("pre_rst_stall", 32'(stall), 32'd1);
        #2;
        rstn = 1'b0;
        #1;
        check_eq("async_rst_bus_req", 32'(bus_req), 32'd0);
        check_eq("async_rst_stall", 32'(stall), 32'd0);
        check_eq("async_rst_readdata", readdata, 32'h0);
        check_eq("async_rst_bus_be", 32'(bus_be), 32'd0);
        mem_req = 1'b0;
        @(posedge clk); #1;
        rstn = 1'b1;

        issue(0, dm_word, 32'h1014, 0, 32'hA5A5_5A5A, 0,
              mk_exp(32'hA5A5_5A5A, 0, 0, 1, 2, 32'h1014, 4'b1111, 0, 32'h0));

        check_eq("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
